// File: rtl/resp_tx_packer.sv
// ---------------------------------------------------------------------------
// resp_tx_packer
//
// Downstream stage of the USB instruction decoder. Every read-response word
// is buffered in a small FIFO and then framed into header-prefixed bursts on a
// valid/ready stream toward the USB transmit path. If fewer than PKT_WORDS
// words are waiting, the partial burst is flushed after TIMEOUT idle cycles.
// This lets a lone register read come back without waiting for a full packet.
//
// Ports:
//   sys_clk, sys_rst_n       clock, asynchronous active-low reset
//   user_valid, user_data    response word strobe and data from the decoder
//   tx_ready                 transmit side accepts the current word
//   tx_valid, tx_data        registered stream word and its valid flag
//   tx_last                  marks the final payload word of a burst
//   clr_overflow             synchronous clear of overflow / drop_cnt
//   overflow                 sticky: at least one response word was dropped
//   drop_cnt                 saturating count of dropped words
//   fifo_level               words currently buffered
// ---------------------------------------------------------------------------
module resp_tx_packer #(
   parameter int          DATA_WIDTH = 32,
   parameter int          DEPTH_LOG2 = 4,
   parameter int          PKT_WORDS  = 8,
   parameter int          TIMEOUT    = 1024,
   parameter logic [15:0] HDR_TAG    = 16'hA55A
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  user_valid,
   input  logic [DATA_WIDTH-1:0] user_data,
   input  logic                  tx_ready,
   output logic                  tx_valid,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_last,
   input  logic                  clr_overflow,
   output logic                  overflow,
   output logic [15:0]           drop_cnt,
   output logic [DEPTH_LOG2:0]   fifo_level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LVL_W = DEPTH_LOG2 + 1;
   localparam int TMO_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} state_t;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
   logic [LVL_W-1:0]      r_level, r_burst_len, r_remaining;
   logic [TMO_W-1:0]      r_tmo;
   state_t                r_state;
   logic                  r_tx_valid, r_tx_last, r_overflow;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic [15:0]           r_drop_cnt;

   logic                  w_full, w_push, w_drop, w_pop, w_tmo_fire, w_start;
   logic [LVL_W-1:0]      w_burst_len;
   logic [DEPTH_LOG2-1:0] w_rd_next;
   logic [DATA_WIDTH-1:0] w_hdr;

   // Full is judged on the registered level only, so a simultaneous pop never
   // makes room for a push in the same cycle.
   assign w_full      = (r_level == LVL_W'(DEPTH));
   assign w_push      = user_valid && !w_full;
   assign w_drop      = user_valid && w_full;
   // In DATA tx_valid is always 1, so tx_ready alone completes a handshake.
   assign w_pop       = (r_state == S_DATA) && tx_ready;
   assign w_tmo_fire  = (r_tmo == TMO_W'(TIMEOUT - 1));
   assign w_burst_len = (r_level >= LVL_W'(PKT_WORDS)) ? LVL_W'(PKT_WORDS) : r_level;
   assign w_start     = (r_state == S_IDLE) &&
                        ((r_level >= LVL_W'(PKT_WORDS)) || (w_tmo_fire && r_level != '0));
   assign w_rd_next   = r_rd_ptr + DEPTH_LOG2'(1);

   // NOTE: every variable written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_hdr        = '0;
      w_hdr[31:16] = HDR_TAG;
      w_hdr[15:0]  = 16'(w_burst_len);
   end

   // NOTE: the storage array has no reset; only the pointers and level are
   // reset, which is enough to make the FIFO empty.
   always_ff @(posedge sys_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= user_data;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // block sees the pre-edge values regardless of evaluation order.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
         if (w_pop)  r_rd_ptr <= w_rd_next;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Idle timer: runs only while a partial burst sits in the FIFO in IDLE.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_tmo <= '0;
      end else if (r_state != S_IDLE || w_push || r_level == '0 ||
                   r_level >= LVL_W'(PKT_WORDS)) begin
         r_tmo <= '0;
      end else if (!w_tmo_fire) begin
         r_tmo <= r_tmo + TMO_W'(1);
      end
   end

   // A drop in the same cycle as a clear wins: the count restarts at 1.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (clr_overflow)              r_drop_cnt <= 16'd1;
         else if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end else if (clr_overflow) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end
   end

   // Framing FSM. The stream outputs change only on a state entry or a
   // handshake, so they hold steady across tx_ready stalls.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state     <= S_IDLE;
         r_tx_valid  <= 1'b0;
         r_tx_last   <= 1'b0;
         r_tx_data   <= '0;
         r_burst_len <= '0;
         r_remaining <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state     <= S_HEADER;
                  r_tx_valid  <= 1'b1;
                  r_tx_data   <= w_hdr;
                  r_tx_last   <= 1'b0;
                  r_burst_len <= w_burst_len;
               end
            end
            S_HEADER: begin
               if (tx_ready) begin
                  r_state     <= S_DATA;
                  r_remaining <= r_burst_len;
                  r_tx_data   <= r_mem[r_rd_ptr];
                  r_tx_last   <= (r_burst_len == LVL_W'(1));
               end
            end
            S_DATA: begin
               if (tx_ready) begin
                  r_remaining <= r_remaining - LVL_W'(1);
                  if (r_remaining == LVL_W'(1)) begin
                     r_state    <= S_IDLE;
                     r_tx_valid <= 1'b0;
                     r_tx_last  <= 1'b0;
                  end else begin
                     // Next payload word was buffered before the burst began.
                     r_tx_data <= r_mem[w_rd_next];
                     r_tx_last <= (r_remaining == LVL_W'(2));
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign tx_valid   = r_tx_valid;
   assign tx_data    = r_tx_data;
   assign tx_last    = r_tx_last;
   assign overflow   = r_overflow;
   assign drop_cnt   = r_drop_cnt;
   assign fifo_level = r_level;

endmodule

// File: tb/tb_resp_tx_packer.sv
// ---------------------------------------------------------------------------
// tb_resp_tx_packer
//
// Directed bench for resp_tx_packer with a shortened idle timeout. A vector
// table covers fill, drop, overflow and clear behaviour cycle by cycle; short
// hand-written sequences cover bursts, stalls, timeout flush and mid-burst
// reset. Inputs change on the falling edge, outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_resp_tx_packer;

   localparam int TMO = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        user_valid = 1'b0;
   logic [31:0] user_data = '0;
   logic        tx_ready = 1'b0;
   logic        clr_overflow = 1'b0;
   logic        tx_valid, tx_last, overflow;
   logic [31:0] tx_data;
   logic [15:0] drop_cnt;
   logic [4:0]  fifo_level;

   resp_tx_packer #(
      .DATA_WIDTH(32), .DEPTH_LOG2(4), .PKT_WORDS(8), .TIMEOUT(TMO), .HDR_TAG(16'hA55A)
   ) dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .user_valid(user_valid), .user_data(user_data),
      .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
      .clr_overflow(clr_overflow), .overflow(overflow), .drop_cnt(drop_cnt),
      .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        uv;
      logic [31:0] ud;
      logic        clr;
      logic [4:0]  lvl;
      logic        ovf;
      logic [15:0] drop;
      logic        vld;
      logic [31:0] dat;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic        l;
   } word_t;

   vec_t  vecs[$];
   word_t got[$];
   word_t exp_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    cyc_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic void add(input logic uv, input logic [31:0] ud, input logic clr,
                               input logic [4:0] lvl, input logic ovf, input logic [15:0] drop,
                               input logic vld, input logic [31:0] dat);
      vecs.push_back(vec_t'{uv, ud, clr, lvl, ovf, drop, vld, dat});
   endfunction

   task automatic push_words(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         user_valid = 1'b1;
         user_data  = base + 32'(i);
         @(negedge clk);
      end
      user_valid = 1'b0;
   endtask

   // Counts rising edges until tx_valid is seen, bounded by budget.
   task automatic wait_valid(input int budget, output int cycles);
      cycles = 0;
      while (!tx_valid && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic add_burst(input logic [31:0] base, input int n);
      exp_q.push_back(word_t'{32'hA55A_0000 | 32'(n), 1'b0});
      for (int i = 0; i < n; i++) exp_q.push_back(word_t'{base + 32'(i), i == n - 1});
   endtask

   // Accepts n stream words; optional tx_ready toggling checks stall stability.
   task automatic run_stream(input int n, input bit toggle);
      logic        prev_stall;
      logic [31:0] prev_data;
      logic        prev_last;
      int          cyc;
      got.delete();
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      cyc        = 0;
      while (got.size() < n && cyc < 200) begin
         if (prev_stall) begin
            check("stall_valid", 32'(tx_valid), 32'd1);
            check("stall_data", tx_data, prev_data);
            check("stall_last", 32'(tx_last), 32'(prev_last));
         end
         tx_ready = toggle ? !tx_ready : 1'b1;
         if (tx_valid && tx_ready) got.push_back(word_t'{tx_data, tx_last});
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         prev_last  = tx_last;
         if (got.size() < n) @(negedge clk);
         cyc++;
      end
      @(posedge clk);
      #1 tx_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic compare_stream(input string name);
      check({name, "_len"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s_data%0d", name, i), got[i].d, exp_q[i].d);
         check($sformatf("%s_last%0d", name, i), 32'(got[i].l), 32'(exp_q[i].l));
      end
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Fill to 16 with tx_ready low, then drop 4, then clear tests.
      add(1, 0,  0, 1,  0, 0, 0, 0);
      add(1, 1,  0, 2,  0, 0, 0, 0);
      add(1, 2,  0, 3,  0, 0, 0, 0);
      add(1, 3,  0, 4,  0, 0, 0, 0);
      add(1, 4,  0, 5,  0, 0, 0, 0);
      add(1, 5,  0, 6,  0, 0, 0, 0);
      add(1, 6,  0, 7,  0, 0, 0, 0);
      add(1, 7,  0, 8,  0, 0, 0, 0);
      add(1, 8,  0, 9,  0, 0, 1, 32'hA55A_0008);
      add(1, 9,  0, 10, 0, 0, 1, 32'hA55A_0008);
      add(1, 10, 0, 11, 0, 0, 1, 32'hA55A_0008);
      add(1, 11, 0, 12, 0, 0, 1, 32'hA55A_0008);
      add(1, 12, 0, 13, 0, 0, 1, 32'hA55A_0008);
      add(1, 13, 0, 14, 0, 0, 1, 32'hA55A_0008);
      add(1, 14, 0, 15, 0, 0, 1, 32'hA55A_0008);
      add(1, 15, 0, 16, 0, 0, 1, 32'hA55A_0008);
      add(1, 16, 0, 16, 1, 1, 1, 32'hA55A_0008);
      add(1, 17, 0, 16, 1, 2, 1, 32'hA55A_0008);
      add(1, 18, 0, 16, 1, 3, 1, 32'hA55A_0008);
      add(1, 19, 0, 16, 1, 4, 1, 32'hA55A_0008);
      add(1, 20, 1, 16, 1, 1, 1, 32'hA55A_0008);
      add(0, 0,  1, 16, 0, 0, 1, 32'hA55A_0008);
      add(0, 0,  0, 16, 0, 0, 1, 32'hA55A_0008);

      repeat (3) @(negedge clk);
      check("rst_valid", 32'(tx_valid), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_data", tx_data, 32'd0);
      check("rst_last", 32'(tx_last), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);

      foreach (vecs[i]) begin
         user_valid   = vecs[i].uv;
         user_data    = vecs[i].ud;
         clr_overflow = vecs[i].clr;
         @(negedge clk);
         check($sformatf("v%0d_level", i), 32'(fifo_level), 32'(vecs[i].lvl));
         check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
         check($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(vecs[i].drop));
         check($sformatf("v%0d_valid", i), 32'(tx_valid), 32'(vecs[i].vld));
         check($sformatf("v%0d_data", i), tx_data, vecs[i].dat);
         check($sformatf("v%0d_last", i), 32'(tx_last), 32'd0);
      end
      user_valid   = 1'b0;
      clr_overflow = 1'b0;

      // Drain the full FIFO: two bursts of 8, dropped words never appear.
      add_burst(32'd0, 8);
      add_burst(32'd8, 8);
      run_stream(18, 1'b0);
      compare_stream("drain16");
      check("drain_level", 32'(fifo_level), 32'd0);
      check("drain_valid", 32'(tx_valid), 32'd0);

      // Full packet: header one edge after the eighth push.
      tx_ready = 1'b1;
      push_words(32'd0, 8);
      check("pkt8_pre_valid", 32'(tx_valid), 32'd0);
      check("pkt8_pre_level", 32'(fifo_level), 32'd8);
      @(negedge clk);
      check("pkt8_hdr_valid", 32'(tx_valid), 32'd1);
      check("pkt8_hdr_data", tx_data, 32'hA55A_0008);
      add_burst(32'd0, 8);
      run_stream(9, 1'b0);
      compare_stream("pkt8");

      // Stalls every other cycle.
      push_words(32'h100, 8);
      wait_valid(8, cyc_cnt);
      check("stall_hdr_lat", 32'(cyc_cnt), 32'd1);
      add_burst(32'h100, 8);
      run_stream(9, 1'b1);
      compare_stream("stall");
      check("stall_level", 32'(fifo_level), 32'd0);

      // Single word flushed by the idle timeout.
      push_words(32'h0001_0203, 1);
      check("single_level", 32'(fifo_level), 32'd1);
      wait_valid(TMO + 10, cyc_cnt);
      check("single_tmo_lat", 32'(cyc_cnt), 32'(TMO));
      check("single_hdr", tx_data, 32'hA55A_0001);
      add_burst(32'h0001_0203, 1);
      run_stream(2, 1'b0);
      compare_stream("single");
      check("single_level_end", 32'(fifo_level), 32'd0);
      check("single_valid_end", 32'(tx_valid), 32'd0);

      // Reset in the middle of a burst, after three payload words.
      push_words(32'h200, 8);
      wait_valid(8, cyc_cnt);
      add_burst(32'h200, 3);
      exp_q[0].d = 32'hA55A_0008;
      exp_q[3].l = 1'b0;
      run_stream(4, 1'b0);
      compare_stream("pre_rst");
      check("mid_valid", 32'(tx_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(tx_valid), 32'd0);
      check("arst_level", 32'(fifo_level), 32'd0);
      check("arst_last", 32'(tx_last), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_level", 32'(fifo_level), 32'd0);
      check("post_rst_valid", 32'(tx_valid), 32'd0);
      push_words(32'h300, 1);
      wait_valid(TMO + 10, cyc_cnt);
      check("post_rst_tmo_lat", 32'(cyc_cnt), 32'(TMO));
      add_burst(32'h300, 1);
      run_stream(2, 1'b0);
      compare_stream("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
